fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one FIFO write port, range 2..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: flit width, equal to the width of the shared FIFO's write data.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, which is the FIFO write clock.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester flit valid.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port req_last, input, NUM_REQ bits: the flit is the packet tail.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: the flit is accepted this cycle.
REQ-009 The block SHALL have port fifo_wr_data, output, DATA_WIDTH bits: data to the FIFO write port.
REQ-010 The block SHALL have port fifo_wr_en, output, 1 bit: FIFO write strobe.
REQ-011 The block SHALL have port fifo_full, input, 1 bit: the FIFO full flag, synchronous to clk.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current owner.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state LOCKED.

Function
REQ-014 The FSM SHALL have two states, IDLE and LOCKED, held in a registered state variable.
REQ-015 IDLE with any req_valid high: at the clock edge the FSM SHALL register the round-robin winner into grant_id and go to LOCKED; no flit is accepted in IDLE.
REQ-016 Round-robin SHALL search upward from rr_ptr, modulo NUM_REQ, for the first valid requester.
REQ-017 IDLE with no req_valid high: the FSM SHALL remain in IDLE, and grant_id and rr_ptr SHALL hold.
REQ-018 In LOCKED, fifo_wr_en SHALL be combinational: req_valid[grant_id] & ~fifo_full.
REQ-019 fifo_wr_data SHALL equal req_data of grant_id, and req_ready[grant_id] SHALL equal fifo_wr_en.
REQ-020 All other req_ready bits SHALL be 0.
REQ-021 In IDLE, fifo_wr_en SHALL be 0, req_ready SHALL be all 0, and fifo_wr_data SHALL be 0.
REQ-022 fifo_full high SHALL stall the owner with no loss or duplication of flits, and the lock SHALL be kept.
REQ-023 A gap in the owner's req_valid mid-packet SHALL keep the lock, and other requesters SHALL wait.
REQ-024 A flit accepted with req_last=1 SHALL return the FSM to IDLE and set rr_ptr to grant_id+1, wrapping from NUM_REQ-1 to 0.
REQ-025 The first flit of a packet SHALL be accepted no earlier than 1 cycle after its req_valid rises (arbitration bubble).
REQ-026 Back-to-back packets SHALL therefore cost one idle cycle each.
REQ-027 req_last on a stalled flit (fifo_full=1) SHALL NOT end the lock.
REQ-028 Requester inputs are AXI-style: after raising req_valid, a requester holds req_valid, req_data and req_last until req_ready; the block SHALL rely on this.

Reset
REQ-029 While rstn=0, the block SHALL hold state=IDLE, rr_ptr=0, grant_id=0, busy=0, fifo_wr_en=0, req_ready=0 and fifo_wr_data=0.
REQ-030 Reset asserted mid-packet SHALL drop the lock immediately, asynchronously.
REQ-031 No partial-packet recovery SHALL be performed; the first cycle after release SHALL be IDLE.

Configuration
REQ-032 Macro FIFO_WR_ARB_PKT_LOCK_EN defined: the lock SHALL persist until the tail flit, as in REQ-024.
REQ-033 Macro FIFO_WR_ARB_PKT_LOCK_EN undefined: every accepted flit SHALL be treated as a tail, giving flit-level round-robin with a one-cycle bubble per flit.
REQ-034 With the macro undefined, req_last SHALL be ignored.

Structure
REQ-035 Package nop_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and a function computing the grant index width.
REQ-036 Sub-module rr_pick SHALL be a combinational round-robin picker with inputs req vector and base pointer, and outputs winner index and any-valid.
REQ-037 The FSM, grant registers and output muxing SHALL stay in fifo_wr_arbiter.

Verification
REQ-038 Scenario, NUM_REQ=4, with FIFO_WR_ARB_PKT_LOCK_EN: requesters 0 and 2 each send 3-flit packets simultaneously, fifo_full=0 -> FIFO receives 3 flits of requester 0, one idle cycle, then 3 flits of requester 2; rr_ptr then equals 3.
REQ-039 Scenario: owner 1 mid-packet while fifo_full=1 for 5 cycles -> fifo_wr_en=0 and req_ready=0 for those 5 cycles; the same flit is written once when full drops.
REQ-040 Scenario: owner 3 deasserts req_valid for 2 cycles mid-packet while requester 0 is valid -> grant_id stays 3 and requester 0 is not served until 3's tail is accepted.
REQ-041 Scenario: rstn pulsed low during the second flit of a 4-flit packet -> all outputs 0 at once; after release, busy rises again only on a new arbitration from rr_ptr=0.
REQ-042 Scenario, without FIFO_WR_ARB_PKT_LOCK_EN: requesters 0 and 1 continuously valid -> written flits alternate 0,1,0,1 with one idle cycle between each.
REQ-043 Scenario: all 4 requesters issue single-flit packets every cycle -> grant order is 0,1,2,3,0, and no requester is starved over 100 cycles.

Source files
------------

// File: rtl/nop_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and the
// grant index width helper used to size grant_id and the round-robin pointer.
package nop_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from base, modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_pick
    import nop_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic [IDX_W-1:0]   winner,
    output logic               any_vld
);

    // Walk offsets from the far end back to zero so the closest requester to base wins.
    always_comb begin
        winner  = '0;
        any_vld = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(base) + i) % NUM_REQ]) begin
                winner = IDX_W'((int'(base) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet/flit round-robin arbiter for one FIFO write port; FIFO_WR_ARB_PKT_LOCK_EN keeps ownership until req_last.
// Latency: one arbitration cycle before the first accepted flit, then one flit per cycle.
// Backpressure: fifo_full stalls the owner in place; ownership is retained while stalled.
module fifo_wr_arbiter
    import nop_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    localparam int GW         = grant_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be in 2..16");
    end

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] rr_ptr_nxt;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] win_idx;
    logic          win_vld;
    logic          owner_vld;
    logic          tail;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GW)
    ) u_rr_pick (
        .req     (req_valid),
        .base    (rr_ptr),
        .winner  (win_idx),
        .any_vld (win_vld)
    );

    assign owner_vld = req_valid[grant_id];

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    assign tail = req_last[grant_id];
`else
    // Flit-level arbitration: every accepted flit releases the port.
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign tail            = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        rr_ptr_nxt   = rr_ptr;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        req_ready    = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = LOCKED;
                    grant_nxt = win_idx;
                end
            end
            LOCKED: begin
                fifo_wr_en          = owner_vld & ~fifo_full;
                fifo_wr_data        = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
                req_ready[grant_id] = fifo_wr_en;
                // A stalled tail is not accepted, so the lock only drops on a real write.
                if (fifo_wr_en && tail) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            grant_id <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=16); follows FIFO_WR_ARB_PKT_LOCK_EN.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [15:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Requester model: flits still to send, packet length, next flit index, forced gap.
    int remain [4];
    int plen   [4];
    int fidx   [4];
    bit gap    [4];

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] flit(input int r, input int f);
        return 16'((r << 12) + f);
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = (remain[i] > 0) && !gap[i];
            req_data[i*16 +: 16]  = flit(i, fidx[i]);
            req_last[i]           = (plen[i] > 0) && (((fidx[i] + 1) % plen[i]) == 0);
        end
    endtask

    // One cycle: drive after the rising edge, sample on the falling edge.
    task automatic tick(input logic full);
        @(posedge clk);
        #1;
        fifo_full = full;
        drive();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
                fidx[i]++;
                remain[i]--;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            remain[i] = 0;
            plen[i]   = 1;
            fidx[i]   = 0;
            gap[i]    = 1'b0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        fifo_full = 1'b0;
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        fifo_full = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 64'h1234_5678_9ABC_DEF0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", fifo_wr_en); end
        n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %0h expected 0", req_ready); end
        n_chk++; if (fifo_wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", fifo_wr_data); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    endtask

    // Requesters 0 and 1 always valid: writes alternate 0,1,0,1 with a bubble between.
    task automatic test_alternate();
        do_reset();
        remain[0] = 8;
        remain[1] = 8;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        plen[0] = 1; plen[1] = 1;
`else
        plen[0] = 100; plen[1] = 100;
`endif
        for (int c = 1; c <= 16; c++) begin
            tick(1'b0);
            n_chk++;
            if (fifo_wr_en !== (c % 2 == 0)) begin
                n_fail++; $display("FAIL alt_wr_en c=%0d: got %0b expected %0b", c, fifo_wr_en, (c % 2 == 0));
            end
            if (c % 2 == 0) begin
                int k;
                k = c / 2 - 1;
                n_chk++;
                if (fifo_wr_data !== flit(k % 2, k / 2)) begin
                    n_fail++; $display("FAIL alt_data c=%0d: got %0h expected %0h", c, fifo_wr_data, flit(k % 2, k / 2));
                end
                n_chk++;
                if (req_ready !== 4'(1 << (k % 2))) begin
                    n_fail++; $display("FAIL alt_ready c=%0d: got %0h expected %0h", c, req_ready, 4'(1 << (k % 2)));
                end
            end
        end
    endtask

    // All four requesters always valid with single-flit packets: order 0,1,2,3,0,...
    task automatic test_all_four();
        int cnt [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            remain[i] = 1000;
            cnt[i]    = 0;
        end
        for (int c = 1; c <= 100; c++) begin
            tick(1'b0);
            for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            if (c % 2 == 0) begin
                int k;
                k = c / 2 - 1;
                n_chk++;
                if (fifo_wr_en !== 1'b1 || grant_id !== 2'(k % 4)) begin
                    n_fail++; $display("FAIL rr4_grant c=%0d: got en=%0b id=%0d expected en=1 id=%0d", c, fifo_wr_en, grant_id, k % 4);
                end
                n_chk++;
                if (fifo_wr_data !== flit(k % 4, k / 4)) begin
                    n_fail++; $display("FAIL rr4_data c=%0d: got %0h expected %0h", c, fifo_wr_data, flit(k % 4, k / 4));
                end
            end else begin
                n_chk++;
                if (fifo_wr_en !== 1'b0) begin
                    n_fail++; $display("FAIL rr4_bubble c=%0d: got %0b expected 0", c, fifo_wr_en);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (cnt[i] != ((i < 2) ? 13 : 12)) begin
                n_fail++; $display("FAIL rr4_count r=%0d: got %0d expected %0d", i, cnt[i], (i < 2) ? 13 : 12);
            end
        end
    endtask

    // Owner 1 stalled by fifo_full for 5 cycles; the held flit is written exactly once.
    task automatic test_full_stall();
        int s;
        int f1_writes;
        do_reset();
        remain[1]  = 3;
        f1_writes  = 0;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        plen[1] = 3;
        s = 3;
`else
        plen[1] = 100;
        s = 4;
`endif
        for (int c = 1; c <= s + 5; c++) begin
            logic full;
            full = (c >= s) && (c <= s + 4);
            tick(full);
            if (fifo_wr_en && fifo_wr_data == flit(1, 1)) f1_writes++;
            if (c == 2) begin
                n_chk++;
                if (fifo_wr_en !== 1'b1 || fifo_wr_data !== flit(1, 0)) begin
                    n_fail++; $display("FAIL stall_first: got en=%0b data=%0h expected en=1 data=%0h", fifo_wr_en, fifo_wr_data, flit(1, 0));
                end
            end
            if (full) begin
                n_chk++;
                if (fifo_wr_en !== 1'b0 || req_ready !== 4'h0 || busy !== 1'b1 || grant_id !== 2'd1) begin
                    n_fail++; $display("FAIL stall_hold c=%0d: got en=%0b rdy=%0h busy=%0b id=%0d expected en=0 rdy=0 busy=1 id=1",
                                       c, fifo_wr_en, req_ready, busy, grant_id);
                end
            end
            if (c == s + 5) begin
                n_chk++;
                if (fifo_wr_en !== 1'b1 || fifo_wr_data !== flit(1, 1) || req_ready !== 4'b0010) begin
                    n_fail++; $display("FAIL stall_release: got en=%0b data=%0h rdy=%0h expected en=1 data=%0h rdy=2",
                                       fifo_wr_en, fifo_wr_data, req_ready, flit(1, 1));
                end
            end
        end
        n_chk++;
        if (f1_writes != 1) begin
            n_fail++; $display("FAIL stall_once: got %0d writes expected 1", f1_writes);
        end
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        // Tail flit stalled: lock must survive.
        tick(1'b1);
        n_chk++;
        if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL stall_tail_hold: got busy=%0b en=%0b expected busy=1 en=0", busy, fifo_wr_en);
        end
`else
        tick(1'b0);
        n_chk++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL stall_bubble: got busy=%0b en=%0b expected busy=0 en=0", busy, fifo_wr_en);
        end
`endif
        tick(1'b0);
        n_chk++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== flit(1, 2)) begin
            n_fail++; $display("FAIL stall_last: got en=%0b data=%0h expected en=1 data=%0h", fifo_wr_en, fifo_wr_data, flit(1, 2));
        end
        tick(1'b0);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_done_busy: got %0b expected 0", busy);
        end
    endtask

    // Reset during the second flit of requester 2; afterwards arbitration restarts from 0.
    task automatic test_reset_mid();
        int n;
        do_reset();
        remain[2] = 4;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        plen[2] = 4;
        n = 3;
`else
        plen[2] = 100;
        n = 4;
`endif
        for (int c = 1; c <= n; c++) tick(1'b0);
        n_chk++;
        if (busy !== 1'b1 || fifo_wr_en !== 1'b1 || grant_id !== 2'd2 || fifo_wr_data !== flit(2, 1)) begin
            n_fail++; $display("FAIL rstmid_pre: got busy=%0b en=%0b id=%0d data=%0h expected busy=1 en=1 id=2 data=%0h",
                               busy, fifo_wr_en, grant_id, fifo_wr_data, flit(2, 1));
        end
        #1;
        rstn = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'h0 || fifo_wr_data !== 16'h0 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_async: got busy=%0b en=%0b rdy=%0h data=%0h id=%0d expected all 0",
                               busy, fifo_wr_en, req_ready, fifo_wr_data, grant_id);
        end
        clear_model();
        drive();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        remain[1] = 1;
        remain[3] = 1;
        tick(1'b0);
        n_chk++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: got busy=%0b en=%0b expected busy=0 en=0", busy, fifo_wr_en);
        end
        tick(1'b0);
        n_chk++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || fifo_wr_data !== flit(1, 0)) begin
            n_fail++; $display("FAIL rstmid_rearb: got busy=%0b id=%0d data=%0h expected busy=1 id=1 data=%0h",
                               busy, grant_id, fifo_wr_data, flit(1, 0));
        end
    endtask

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    // Requesters 0 and 2 send 3-flit packets together; then rr_ptr must sit at 3.
    task automatic test_pkt_lock();
        do_reset();
        remain[0] = 3; plen[0] = 3;
        remain[2] = 3; plen[2] = 3;
        for (int c = 1; c <= 9; c++) begin
            tick(1'b0);
            if (c >= 2 && c <= 4) begin
                n_chk++;
                if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0 || fifo_wr_data !== flit(0, c - 2)) begin
                    n_fail++; $display("FAIL pkt_r0 c=%0d: got en=%0b id=%0d data=%0h expected en=1 id=0 data=%0h",
                                       c, fifo_wr_en, grant_id, fifo_wr_data, flit(0, c - 2));
                end
            end else if (c >= 6 && c <= 8) begin
                n_chk++;
                if (fifo_wr_en !== 1'b1 || grant_id !== 2'd2 || fifo_wr_data !== flit(2, c - 6)) begin
                    n_fail++; $display("FAIL pkt_r2 c=%0d: got en=%0b id=%0d data=%0h expected en=1 id=2 data=%0h",
                                       c, fifo_wr_en, grant_id, fifo_wr_data, flit(2, c - 6));
                end
            end else begin
                n_chk++;
                if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL pkt_idle c=%0d: got en=%0b busy=%0b expected en=0 busy=0", c, fifo_wr_en, busy);
                end
            end
        end
        remain[0] = 1; plen[0] = 1;
        remain[3] = 1; plen[3] = 1;
        tick(1'b0);
        tick(1'b0);
        n_chk++;
        if (busy !== 1'b1 || grant_id !== 2'd3) begin
            n_fail++; $display("FAIL pkt_rrptr: got busy=%0b id=%0d expected busy=1 id=3", busy, grant_id);
        end
    endtask

    // Owner 3 pauses mid-packet while requester 0 waits; lock must hold.
    task automatic test_gap();
        do_reset();
        remain[3] = 4; plen[3] = 4;
        tick(1'b0);
        remain[0] = 1; plen[0] = 1;
        for (int c = 2; c <= 8; c++) begin
            gap[3] = (c == 3) || (c == 4);
            tick(1'b0);
            n_chk++;
            if (req_ready[0] !== 1'b0) begin
                n_fail++; $display("FAIL gap_r0_wait c=%0d: got %0b expected 0", c, req_ready[0]);
            end
            if (c == 3 || c == 4) begin
                n_chk++;
                if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin
                    n_fail++; $display("FAIL gap_hold c=%0d: got en=%0b busy=%0b id=%0d expected en=0 busy=1 id=3",
                                       c, fifo_wr_en, busy, grant_id);
                end
            end else if (c != 8) begin
                n_chk++;
                if (fifo_wr_en !== 1'b1 || grant_id !== 2'd3 || fifo_wr_data !== flit(3, (c == 2) ? 0 : c - 4)) begin
                    n_fail++; $display("FAIL gap_flit c=%0d: got en=%0b id=%0d data=%0h expected en=1 id=3 data=%0h",
                                       c, fifo_wr_en, grant_id, fifo_wr_data, flit(3, (c == 2) ? 0 : c - 4));
                end
            end
        end
        tick(1'b0);
        n_chk++;
        if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0 || fifo_wr_data !== flit(0, 0)) begin
            n_fail++; $display("FAIL gap_r0_served: got en=%0b id=%0d data=%0h expected en=1 id=0 data=%0h",
                               fifo_wr_en, grant_id, fifo_wr_data, flit(0, 0));
        end
    endtask
`endif

    initial begin
        clear_model();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        rstn      = 1'b0;
        test_reset();
        test_alternate();
        test_all_four();
        test_full_stall();
        test_reset_mid();
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        test_pkt_lock();
        test_gap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
